// File: rtl/mem_responder.sv
// Memory-side responder: per-channel fixed-latency read/write completion over a register array,
// plus a backdoor load port. Define MEM_RESPONDER_STATS_EN to add completed-request counters.
module mem_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 16,
    parameter int NUM_CHANNELS = 1,
    parameter int LATENCY      = 2,
    parameter int WRITE_ENABLE = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
    output logic [NUM_CHANNELS-1:0]                mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
    output logic [NUM_CHANNELS-1:0]                mem_write_ready,
    input  logic                                   load_valid,
    input  logic [ADDR_BITS-1:0]                   load_address,
    input  logic [DATA_BITS-1:0]                   load_data
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]                            read_count,
    output logic [15:0]                            write_count
`endif
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [DATA_BITS-1:0]    mem_r   [DEPTH];
    state_t                  state_r [NUM_CHANNELS];
    state_t                  state_s [NUM_CHANNELS];
    logic [7:0]              cnt_r   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]    addr_r  [NUM_CHANNELS];
    logic [DATA_BITS-1:0]    wdata_r [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_wr_r;
    logic [NUM_CHANNELS-1:0] fire_s;
    logic [NUM_CHANNELS-1:0] commit_s;

    // Next-state decode; fire marks the edge on which a request completes
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_s[c]  = state_r[c];
            fire_s[c]   = 1'b0;
            commit_s[c] = 1'b0;
            case (state_r[c])
                S_IDLE: begin
                    if (mem_read_valid[c] || mem_write_valid[c]) begin
                        state_s[c] = S_WAIT;
                    end else begin
                        state_s[c] = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_r[c] == 8'd0) begin
                        state_s[c]  = S_DONE;
                        fire_s[c]   = 1'b1;
                        commit_s[c] = op_wr_r[c] && (WRITE_ENABLE != 0);
                    end else begin
                        state_s[c] = S_WAIT;
                    end
                end
                S_DONE: begin
                    // Leave only once the request that was served has been withdrawn
                    if (op_wr_r[c] ? !mem_write_valid[c] : !mem_read_valid[c]) begin
                        state_s[c] = S_IDLE;
                    end else begin
                        state_s[c] = S_DONE;
                    end
                end
                default: begin
                    state_s[c] = S_IDLE;
                end
            endcase
        end
    end

    // Channel state, request capture, latency countdown and registered responses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_r[c] <= S_IDLE;
                cnt_r[c]   <= 8'd0;
                addr_r[c]  <= '0;
                wdata_r[c] <= '0;
            end
            op_wr_r         <= '0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_r[c]         <= state_s[c];
                mem_read_ready[c]  <= fire_s[c] && !op_wr_r[c];
                mem_write_ready[c] <= fire_s[c] && op_wr_r[c];
                if (state_r[c] == S_IDLE && (mem_read_valid[c] || mem_write_valid[c])) begin
                    op_wr_r[c] <= !mem_read_valid[c];
                    addr_r[c]  <= mem_read_valid[c] ? mem_read_address[c] : mem_write_address[c];
                    wdata_r[c] <= mem_write_data[c];
                    cnt_r[c]   <= 8'(LATENCY - 1);
                end else if (state_r[c] == S_WAIT && cnt_r[c] != 8'd0) begin
                    cnt_r[c] <= cnt_r[c] - 8'd1;
                end
                if (fire_s[c] && !op_wr_r[c]) begin
                    mem_read_data[c] <= mem_r[addr_r[c]];
                end
            end
        end
    end

    // Array writes: load first so channel commits override it, higher channel index last
    always_ff @(posedge clk) begin
        if (load_valid) begin
            mem_r[load_address] <= load_data;
        end
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (commit_s[c]) begin
                mem_r[addr_r[c]] <= wdata_r[c];
            end
        end
    end

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rd_inc_s;
    logic [15:0] wr_inc_s;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Completions across all channels on this edge
    always_comb begin
        rd_inc_s = 16'd0;
        wr_inc_s = 16'd0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (fire_s[c] && op_wr_r[c]) begin
                wr_inc_s = wr_inc_s + 16'd1;
            end else if (fire_s[c]) begin
                rd_inc_s = rd_inc_s + 16'd1;
            end else begin
                rd_inc_s = rd_inc_s;
            end
        end
    end

    // Saturating completion counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else begin
            read_count  <= sat_add(read_count, rd_inc_s);
            write_count <= sat_add(write_count, wr_inc_s);
        end
    end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a 2-channel LATENCY=2 writable instance and a
// 1-channel LATENCY=1 read-only instance; expected completions are queued and matched by a monitor.
module tb_mem_responder;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       a_rv, a_rr, a_wv, a_wr;
    logic [1:0][7:0]  a_ra, a_wa;
    logic [1:0][15:0] a_rd, a_wd;
    logic             a_lv;
    logic [7:0]       a_la;
    logic [15:0]      a_ld;
    logic [0:0]       b_rv, b_rr, b_wv, b_wr;
    logic [0:0][7:0]  b_ra, b_wa;
    logic [0:0][15:0] b_rd, b_wd;
    logic             b_lv;
    logic [7:0]       b_la;
    logic [15:0]      b_ld;
`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] a_rc, a_wc, b_rc, b_wc;
`endif

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(2), .LATENCY(2), .WRITE_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset),
        .mem_read_valid(a_rv), .mem_read_address(a_ra), .mem_read_ready(a_rr), .mem_read_data(a_rd),
        .mem_write_valid(a_wv), .mem_write_address(a_wa), .mem_write_data(a_wd), .mem_write_ready(a_wr),
        .load_valid(a_lv), .load_address(a_la), .load_data(a_ld)
`ifdef MEM_RESPONDER_STATS_EN
        , .read_count(a_rc), .write_count(a_wc)
`endif
    );

    mem_responder #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(1), .LATENCY(1), .WRITE_ENABLE(0)) dut_b (
        .clk(clk), .reset(reset),
        .mem_read_valid(b_rv), .mem_read_address(b_ra), .mem_read_ready(b_rr), .mem_read_data(b_rd),
        .mem_write_valid(b_wv), .mem_write_address(b_wa), .mem_write_data(b_wd), .mem_write_ready(b_wr),
        .load_valid(b_lv), .load_address(b_la), .load_data(b_ld)
`ifdef MEM_RESPONDER_STATS_EN
        , .read_count(b_rc), .write_count(b_wc)
`endif
    );

    typedef struct {
        int          dut;
        int          tag;
        int          cyc;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp_v);
        end
    endtask

    task automatic observe(input int dut, input int ch, input bit wr, input logic [15:0] data);
        int idx;
        int tag;
        idx = -1;
        tag = ch * 2 + (wr ? 1 : 0);
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].dut == dut && sb[i].tag == tag) idx = i;
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL unexpected_%s dut%0d ch%0d: got ready at cycle %0d, required no ready",
                     wr ? "write" : "read", dut, ch, cyc);
        end else begin
            if (sb[idx].cyc != cyc || (!wr && data !== sb[idx].data)) begin
                errors++;
                $display("FAIL %s dut%0d ch%0d: got cycle %0d data %h, required cycle %0d data %h",
                         wr ? "write" : "read", dut, ch, cyc, data, sb[idx].cyc, sb[idx].data);
            end
            sb.delete(idx);
        end
    endtask

    // Monitor: every ready pulse must match a queued expectation
    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (a_rr[ch] === 1'b1) observe(0, ch, 1'b0, a_rd[ch]);
            if (a_wr[ch] === 1'b1) observe(0, ch, 1'b1, 16'h0000);
        end
        if (b_rr[0] === 1'b1) observe(1, 0, 1'b0, b_rd[0]);
        if (b_wr[0] === 1'b1) observe(1, 0, 1'b1, 16'h0000);
    end

    task automatic drive(input int dut, input int ch, input bit wr, input logic [7:0] addr,
                         input logic [15:0] wd, input logic v);
        if (dut == 0) begin
            if (wr) begin
                a_wv[ch] = v; a_wa[ch] = addr; a_wd[ch] = wd;
            end else begin
                a_rv[ch] = v; a_ra[ch] = addr;
            end
        end else begin
            if (wr) begin
                b_wv[0] = v; b_wa[0] = addr; b_wd[0] = wd;
            end else begin
                b_rv[0] = v; b_ra[0] = addr;
            end
        end
    endtask

    task automatic load(input int dut, input logic [7:0] addr, input logic [15:0] data);
        @(negedge clk);
        if (dut == 0) begin
            a_lv = 1'b1; a_la = addr; a_ld = data;
        end else begin
            b_lv = 1'b1; b_la = addr; b_ld = data;
        end
        @(negedge clk);
        a_lv = 1'b0;
        b_lv = 1'b0;
    endtask

    // One request: accepted on the next edge, inputs scrambled afterwards to prove they are latched
    task automatic access(input int dut, input int ch, input bit wr, input logic [7:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_d);
        int lat;
        lat = (dut == 0) ? 2 : 1;
        @(negedge clk);
        drive(dut, ch, wr, addr, wd, 1'b1);
        sb.push_back('{dut, ch * 2 + (wr ? 1 : 0), cyc + 1 + lat, exp_d});
        @(negedge clk);
        drive(dut, ch, wr, ~addr, ~wd, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        a_rv = 2'b00; a_wv = 2'b00; a_ra = '0; a_wa = '0; a_wd = '0;
        a_lv = 1'b0; a_la = 8'h00; a_ld = 16'h0000;
        b_rv = 1'b0; b_wv = 1'b0; b_ra = '0; b_wa = '0; b_wd = '0;
        b_lv = 1'b0; b_la = 8'h00; b_ld = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_read_ready", {14'd0, a_rr}, 16'h0000);
        chk("reset_write_ready", {14'd0, a_wr}, 16'h0000);
        chk("reset_read_data0", a_rd[0], 16'h0000);
        chk("reset_read_data1", a_rd[1], 16'h0000);
        chk("reset_read_data_b", b_rd[0], 16'h0000);
        reset = 1'b1;

        load(0, 8'h12, 16'hBEEF);
        access(0, 0, 1'b0, 8'h12, 16'h0000, 16'hBEEF);
        chk("read_data_held", a_rd[0], 16'hBEEF);

        access(0, 0, 1'b1, 8'h05, 16'h1234, 16'h0000);
        access(0, 0, 1'b0, 8'h05, 16'h0000, 16'h1234);

        // Held read: one pulse only, no re-accept until valid drops
        @(negedge clk);
        a_rv[0] = 1'b1; a_ra[0] = 8'h12;
        sb.push_back('{0, 0, cyc + 3, 16'hBEEF});
        repeat (7) @(negedge clk);
        a_rv[0] = 1'b0;
        repeat (4) @(negedge clk);

        // Both channels write one address on the same edge; channel 1 wins
        @(negedge clk);
        a_wv = 2'b11; a_wa[0] = 8'h07; a_wa[1] = 8'h07; a_wd[0] = 16'hAAAA; a_wd[1] = 16'h5555;
        sb.push_back('{0, 1, cyc + 3, 16'h0000});
        sb.push_back('{0, 3, cyc + 3, 16'h0000});
        @(negedge clk);
        a_wv = 2'b00;
        repeat (4) @(negedge clk);
        access(0, 1, 1'b0, 8'h07, 16'h0000, 16'h5555);
        access(0, 0, 1'b0, 8'h07, 16'h0000, 16'h5555);

        // Read and write together: read first with old data, write accepted after read completes
        load(0, 8'h20, 16'h0F0F);
        @(negedge clk);
        a_rv[0] = 1'b1; a_ra[0] = 8'h20; a_wv[0] = 1'b1; a_wa[0] = 8'h20; a_wd[0] = 16'hA5A5;
        sb.push_back('{0, 0, cyc + 3, 16'h0F0F});
        sb.push_back('{0, 1, cyc + 7, 16'h0000});
        @(negedge clk);
        a_rv[0] = 1'b0;
        repeat (4) @(negedge clk);
        a_wv[0] = 1'b0;
        repeat (4) @(negedge clk);
        access(0, 0, 1'b0, 8'h20, 16'h0000, 16'hA5A5);

        // Channel commit and load land on the same edge; channel write wins
        @(negedge clk);
        a_wv[0] = 1'b1; a_wa[0] = 8'h30; a_wd[0] = 16'h1111;
        sb.push_back('{0, 1, cyc + 3, 16'h0000});
        @(negedge clk);
        a_wv[0] = 1'b0;
        @(negedge clk);
        a_lv = 1'b1; a_la = 8'h30; a_ld = 16'h2222;
        @(negedge clk);
        a_lv = 1'b0;
        repeat (3) @(negedge clk);
        access(0, 0, 1'b0, 8'h30, 16'h0000, 16'h1111);

        // Read-only instance with LATENCY=1
        load(1, 8'h03, 16'h0001);
        access(1, 0, 1'b1, 8'h03, 16'hFFFF, 16'h0000);
        access(1, 0, 1'b0, 8'h03, 16'h0000, 16'h0001);

`ifdef MEM_RESPONDER_STATS_EN
        chk("stats_read_count", a_rc, 16'd8);
        chk("stats_write_count", a_wc, 16'd5);
`endif

        // Reset during WAIT of a write: no pulse, no commit
        @(negedge clk);
        a_wv[0] = 1'b1; a_wa[0] = 8'h05; a_wd[0] = 16'h9999;
        @(negedge clk);
        a_wv[0] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_write_ready", {14'd0, a_wr}, 16'h0000);
        chk("abort_read_data", a_rd[0], 16'h0000);
`ifdef MEM_RESPONDER_STATS_EN
        chk("abort_read_count", a_rc, 16'd0);
        chk("abort_write_count", a_wc, 16'd0);
`endif
        reset = 1'b1;
        repeat (3) @(negedge clk);
        access(0, 0, 1'b0, 8'h05, 16'h0000, 16'h1234);
`ifdef MEM_RESPONDER_STATS_EN
        chk("post_reset_read_count", a_rc, 16'd1);
`endif

        repeat (5) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: got %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
